// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed 7-segment driver for a bank of BCD digits.
// New digits arrive through a valid/ready handshake into a pending buffer. They
// are copied into the display buffer only at a frame boundary, so a frame never
// shows a mix of old and new digits. Digits are lit one at a time, and every
// digit is followed by a blanking gap that keeps the previous digit from ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_scan_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 50,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] ST_ON    = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    // Active-high segment pattern {g,f,e,d,c,b,a}; codes 10-15 are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [0:0]            st_q, st_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    digits_t               disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic                  swap;
    logic                  accept;
    logic                  digit_blank;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [6:0]            seg_raw;
    digits_t               bcd_digits;

    // Split the flat input bus into per-digit nibbles.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
        assign bcd_digits[gi] = bcd_in[4*gi +: 4];
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A zero digit is blanked when no nonzero digit sits above it; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input digits_t d);
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (d[i] != 4'd0) begin
                seen = 1'b1;
            end
            m[i] = ~seen;
        end
        return m;
    endfunction

    localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    logic [NUM_DIGITS-1:0] blank_q, blank_d;

    // Leading-zero mask follows the display buffer and is recomputed only on a swap.
    always_comb begin
        blank_d = swap ? lz_mask(pend_q) : blank_q;
    end

    // Mask register; the reset value matches an all-zero display buffer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blank_q <= BLANK_RST;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign digit_blank = blank_d[idx_d];
`else
    assign digit_blank = 1'b0;
`endif

    // Scan sequencer: ON/BLANK timing, digit index, and frame boundary detection.
    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (st_q == ST_ON) begin
            if (cnt_q == SCAN_LAST) begin
                st_d  = ST_BLANK;
                cnt_d = '0;
            end
        end else begin
            if (cnt_q == BLANK_LAST) begin
                st_d     = ST_ON;
                cnt_d    = '0;
                boundary = (idx_q == IDX_LAST);
                idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign accept   = in_valid & ~pending_q;
    assign swap     = boundary & pending_q;
    assign in_ready = ~pending_q;

    // Buffers: accept into pending, move pending to display at a frame boundary.
    always_comb begin
        pend_d    = accept ? bcd_digits : pend_q;
        pend_dp_d = accept ? dp_in : pend_dp_q;
        disp_d    = swap ? pend_q : disp_q;
        disp_dp_d = swap ? pend_dp_q : disp_dp_q;
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
    end

    // Output drive is computed from next-state values so pins change with st/idx.
    always_comb begin
        an_onehot        = '0;
        an_onehot[idx_d] = 1'b1;
        seg_raw          = digit_blank ? 7'h00 : seg_decode(disp_d[idx_d]);
        an_d             = AN_OFF;
        seg_d            = SEG_OFF;
        dp_d             = DP_OFF;
        frame_done_d     = boundary;
        if (st_d == ST_ON) begin
            an_d  = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dp_d  = (SEG_ACTIVE_LOW != 0) ? ~disp_dp_d[idx_d] : disp_dp_d[idx_d];
        end
    end

    // State, buffers and registered outputs; reset discards any pending data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q         <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= IDX_LAST;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_done_q <= 1'b0;
        end else begin
            st_q         <= st_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
